mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter LITTLE_ENDIAN, default 1, meaning 1 = low byte at base address and 0 = high byte at base address.
REQ-002 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  pipeline access request.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_wide  input  1  1 = 16-bit access, 0 = 8-bit access.
REQ-009 req_addr  input  8  byte address.
REQ-010 req_wdata  input  16  store data; only [7:0] is used when narrow.
REQ-011 resp_valid  output  1  one-cycle completion pulse for loads and stores.
REQ-012 resp_rdata  output  16  load result.
REQ-013 mem_address  output  8  drives the data memory address_in_bus.
REQ-014 mem_data_out  output  8  drives the data memory data_in_bus.
REQ-015 mem_data_in  input  8  driven from the data memory data_out_bus (combinational read).
REQ-016 mem_read_not_write  output  1  drives read_not_write, where 0 = write.

Function
REQ-017 FSM states SHALL be IDLE, BYTE0, BYTE1 and RESP.
REQ-018 req_ready SHALL equal (state == IDLE); a request is accepted on a rising edge with req_valid && req_ready, and all req_* fields are latched at that edge.
REQ-019 IDLE->BYTE0 on accept; BYTE0->BYTE1 if the access is wide, else BYTE0->RESP; BYTE1->RESP; RESP->IDLE unconditionally.
REQ-020 In BYTE0, mem_address SHALL be the latched base address; in BYTE1 it SHALL be base+1 mod 256, so 0xFF wraps to 0x00.
REQ-021 Byte selection: with LITTLE_ENDIAN=1, BYTE0 carries data[7:0] and BYTE1 carries data[15:8]; the order is swapped when LITTLE_ENDIAN=0.
REQ-022 For stores, mem_read_not_write SHALL be 0 for exactly the BYTE0 and BYTE1 cycles, with address and data stable for the whole cycle; in every other state it SHALL be 1.
REQ-023 For loads, mem_read_not_write SHALL stay 1, and mem_data_in SHALL be captured at the rising edge ending BYTE0 and BYTE1.
REQ-024 Narrow load result SHALL be zero-extended to 16 bits.
REQ-025 resp_valid SHALL be 1 only in RESP.
REQ-026 resp_rdata SHALL update only when a load completes and SHALL hold its value through later stores.
REQ-027 Latency from accept edge to resp_valid SHALL be 2 cycles for narrow and 3 cycles for wide accesses.
REQ-028 Minimum request spacing SHALL be 3 cycles narrow and 4 cycles wide.
REQ-029 req_valid held during busy states SHALL be ignored and SHALL NOT be latched.
REQ-030 mem_data_out SHALL be 0x00 whenever the unit is not performing a store.

Reset
REQ-031 While rst_n = 0, the state SHALL be IDLE.
REQ-032 While rst_n = 0, outputs SHALL be: mem_read_not_write = 1, mem_address = 0x00, mem_data_out = 0x00, resp_valid = 0, resp_rdata = 0x0000, and req_ready = 1 after release.
REQ-033 Reset asserted mid-access SHALL abort the access immediately with no response.
REQ-034 A wide store aborted in BYTE1 SHALL leave byte0 written and byte1 unwritten.

Structure
REQ-035 Package mem_access_pkg SHALL hold the state enum, ADDR_W = 8, BYTE_W = 8 and WORD_W = 16.
REQ-036 The unit SHALL be a single module with no sub-modules.
REQ-037 data_memory SHALL be instantiated only in the bench, alongside the unit, and SHALL NOT be instantiated inside the unit.

Verification
REQ-038 Narrow store 0x50 to 0x10, then narrow load from 0x10 -> resp_rdata = 0x0050, with resp_valid 2 cycles after the load accept.
REQ-039 Narrow store 0x30 to 0x10, then load from 0x10 -> resp_rdata = 0x0030 (overwrite confirmed).
REQ-040 Wide store 0xBEEF to 0xFF (LITTLE_ENDIAN=1) -> mem[0xFF] = 0xEF and mem[0x00] = 0xBE; a wide load from 0xFF -> resp_rdata = 0xBEEF.
REQ-041 req_valid held high continuously with narrow loads -> accepts exactly every 3 cycles, and req_ready is 0 in BYTE0 and RESP.
REQ-042 Wide store 0x1234 to 0x20 with rst_n pulled low during BYTE1 -> mem[0x20] = 0x34, mem[0x21] unchanged, no resp_valid, mem_read_not_write = 1 during reset.
REQ-043 Narrow load from 0x10 after the 0x30 store, followed by a store -> resp_rdata holds 0x0030 through the store's RESP cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared widths and FSM state encoding for the byte-serial memory access unit.
package mem_access_pkg;

    localparam int ADDR_W = 8;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_access_unit.sv
// Serialises 8/16-bit pipeline loads and stores onto an 8-bit data memory port,
// one byte per cycle, with a one-cycle completion pulse.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int LITTLE_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_wide,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BYTE_W-1:0] mem_data_out,
    input  logic [BYTE_W-1:0] mem_data_in,
    output logic              mem_read_not_write
);

    state_t            state;
    logic              is_write;
    logic              is_wide;
    logic [ADDR_W-1:0] base_addr;
    logic [BYTE_W-1:0] second_byte;
    logic [BYTE_W-1:0] first_rd;
    logic [BYTE_W-1:0] first_byte;
    logic [BYTE_W-1:0] next_second_byte;

    assign req_ready = (state == IDLE);

    // Narrow stores always send [7:0]; only wide accesses honour the byte order.
    always_comb begin
        first_byte       = req_wdata[7:0];
        next_second_byte = req_wdata[15:8];
        if (req_wide && (LITTLE_ENDIAN == 0)) begin
            first_byte       = req_wdata[15:8];
            next_second_byte = req_wdata[7:0];
        end
    end

    // Memory-side outputs are registered one edge ahead so they are stable for a whole byte cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            is_write           <= 1'b0;
            is_wide            <= 1'b0;
            base_addr          <= '0;
            second_byte        <= '0;
            first_rd           <= '0;
            resp_valid         <= 1'b0;
            resp_rdata         <= '0;
            mem_address        <= '0;
            mem_data_out       <= '0;
            mem_read_not_write <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state              <= BYTE0;
                        is_write           <= req_write;
                        is_wide            <= req_wide;
                        base_addr          <= req_addr;
                        second_byte        <= next_second_byte;
                        mem_address        <= req_addr;
                        mem_read_not_write <= ~req_write;
                        mem_data_out       <= req_write ? first_byte : '0;
                    end
                end
                BYTE0: begin
                    if (!is_write) begin
                        first_rd <= mem_data_in;
                    end
                    if (is_wide) begin
                        state        <= BYTE1;
                        mem_address  <= base_addr + ADDR_W'(1);
                        mem_data_out <= is_write ? second_byte : '0;
                    end else begin
                        state              <= RESP;
                        mem_address        <= '0;
                        mem_data_out       <= '0;
                        mem_read_not_write <= 1'b1;
                        resp_valid         <= 1'b1;
                        if (!is_write) begin
                            resp_rdata <= {{(WORD_W-BYTE_W){1'b0}}, mem_data_in};
                        end
                    end
                end
                BYTE1: begin
                    state              <= RESP;
                    mem_address        <= '0;
                    mem_data_out       <= '0;
                    mem_read_not_write <= 1'b1;
                    resp_valid         <= 1'b1;
                    if (!is_write) begin
                        resp_rdata <= (LITTLE_ENDIAN != 0) ? {mem_data_in, first_rd}
                                                           : {first_rd, mem_data_in};
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: accepts push expected responses, a negedge monitor pops and compares;
// the data memory is modelled here as a 256-byte array with combinational read.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_wide = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [7:0]  mem_address;
    logic [7:0]  mem_data_out;
    logic [7:0]  mem_data_in;
    logic        mem_read_not_write;

    always #5 clk = ~clk;

    mem_access_unit #(.LITTLE_ENDIAN(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_write          (req_write),
        .req_wide           (req_wide),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .resp_valid         (resp_valid),
        .resp_rdata         (resp_rdata),
        .mem_address        (mem_address),
        .mem_data_out       (mem_data_out),
        .mem_data_in        (mem_data_in),
        .mem_read_not_write (mem_read_not_write)
    );

    // Data memory: preloaded with addr ^ 0xA5, written on the rising edge when read_not_write is 0.
    logic [7:0] mem [256];
    logic       mem_loaded = 1'b0;

    assign mem_data_in = mem[mem_address];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem_loaded <= 1'b1;
        end else if (!mem_read_not_write) begin
            mem[mem_address] <= mem_data_out;
        end
    end

    typedef struct {
        logic [15:0] rdata;
        int          lat;
        int          accept_cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          accept_log[$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    int          resp_count = 0;
    logic [15:0] pend_rdata = 16'h0000;
    int          pend_lat = 2;
    bit          pend_expect = 1'b1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at cycle %0d",
                     name, actual, expected, cycle);
        end
    endtask

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst_n && req_valid && req_ready) begin
            accept_log.push_back(cycle + 1);
            if (pend_expect) exp_q.push_back('{pend_rdata, pend_lat, cycle + 1});
        end
    end

    // Monitor: data_out must idle at zero outside stores; every response is matched to the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read_not_write)
                check_output("dout_idle_zero", 32'(mem_data_out), 32'h0);
            if (resp_valid) begin
                resp_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_resp actual=resp_valid 1 expected=no response at cycle %0d",
                             cycle);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                    check_output("resp_latency", 32'(cycle + 1 - e.accept_cycle), 32'(e.lat));
                    check_output("ready_in_resp", 32'(req_ready), 32'h0);
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_output("ready_timeout", 32'(req_ready), 32'h1);
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(req_ready && exp_q.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("drain_queue", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic apply_stimulus(input bit wr, input bit wide, input logic [7:0] addr,
                                  input logic [15:0] wdata, input logic [15:0] exp_rdata);
        wait_ready();
        pend_rdata  = exp_rdata;
        pend_lat    = wide ? 3 : 2;
        pend_expect = 1'b1;
        req_write   = wr;
        req_wide    = wide;
        req_addr    = addr;
        req_wdata   = wdata;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    initial begin
        int n0;
        int rc0;

        repeat (2) @(negedge clk);
        check_output("rst_rnw", 32'(mem_read_not_write), 32'h1);
        check_output("rst_addr", 32'(mem_address), 32'h0);
        check_output("rst_dout", 32'(mem_data_out), 32'h0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'h0);
        check_output("rst_rdata", 32'(resp_rdata), 32'h0);
        check_output("rst_ready", 32'(req_ready), 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("ready_after_rst", 32'(req_ready), 32'h1);

        // Narrow store/load/overwrite; stores report the last load result unchanged.
        apply_stimulus(1'b1, 1'b0, 8'h10, 16'h0050, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 8'h10, 16'h0000, 16'h0050);
        apply_stimulus(1'b1, 1'b0, 8'h10, 16'h0030, 16'h0050);
        apply_stimulus(1'b0, 1'b0, 8'h10, 16'h0000, 16'h0030);
        apply_stimulus(1'b1, 1'b0, 8'h40, 16'h00AA, 16'h0030);
        apply_stimulus(1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h0030);
        wait_done();
        check_output("mem_ff", 32'(mem[255]), 32'hEF);
        check_output("mem_00", 32'(mem[0]), 32'hBE);
        check_output("mem_40", 32'(mem[64]), 32'hAA);
        apply_stimulus(1'b0, 1'b1, 8'hFF, 16'h0000, 16'hBEEF);
        wait_done();

        // req_valid held high with narrow loads: ready pattern 0,0,1 and accepts 3 cycles apart.
        n0          = accept_log.size();
        pend_rdata  = 16'h0030;
        pend_lat    = 2;
        pend_expect = 1'b1;
        req_write   = 1'b0;
        req_wide    = 1'b0;
        req_addr    = 8'h10;
        req_valid   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_output("held_ready", 32'(req_ready), (i % 3 == 2) ? 32'h1 : 32'h0);
        end
        req_valid = 1'b0;
        wait_done();
        check_output("held_accepts", 32'(accept_log.size() - n0), 32'h4);
        for (int k = n0 + 1; k < accept_log.size(); k++)
            check_output("held_spacing", 32'(accept_log[k] - accept_log[k-1]), 32'h3);

        // Wide store to 0x20 aborted by reset during its second byte.
        rc0 = resp_count;
        wait_ready();
        pend_expect = 1'b0;
        req_write   = 1'b1;
        req_wide    = 1'b1;
        req_addr    = 8'h20;
        req_wdata   = 16'h1234;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_output("byte0_rnw", 32'(mem_read_not_write), 32'h0);
        check_output("byte0_addr", 32'(mem_address), 32'h20);
        check_output("byte0_dout", 32'(mem_data_out), 32'h34);
        @(negedge clk);
        check_output("byte1_addr", 32'(mem_address), 32'h21);
        check_output("byte1_dout", 32'(mem_data_out), 32'h12);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort_rnw", 32'(mem_read_not_write), 32'h1);
        check_output("abort_addr", 32'(mem_address), 32'h0);
        check_output("abort_dout", 32'(mem_data_out), 32'h0);
        check_output("abort_resp_valid", 32'(resp_valid), 32'h0);
        check_output("abort_ready", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        check_output("abort_rnw_held", 32'(mem_read_not_write), 32'h1);
        rst_n = 1'b1;
        pend_expect = 1'b1;
        repeat (3) @(negedge clk);
        check_output("abort_no_resp", 32'(resp_count - rc0), 32'h0);
        check_output("abort_mem_20", 32'(mem[32]), 32'h34);
        check_output("abort_mem_21", 32'(mem[33]), 32'h84);
        check_output("abort_rdata", 32'(resp_rdata), 32'h0);

        apply_stimulus(1'b0, 1'b0, 8'h20, 16'h0000, 16'h0034);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
